// File: rtl/gpr_regfile_keydec_pkg.sv
// Shared defaults and constants for the decode-stage GPR file.
package gpr_regfile_keydec_pkg;

  localparam int unsigned DEF_XLEN    = 64;
  localparam int unsigned DEF_NR_REG  = 32;
  localparam int unsigned DEF_REG_SEL = 5;
  localparam int unsigned ZERO_REG    = 0;

endpackage

// File: rtl/gpr_regfile_keydec_if.sv
// Write/read/debug bundle between the decode stage and the GPR file.
interface gpr_regfile_keydec_if
  import gpr_regfile_keydec_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned NR_REG  = DEF_NR_REG,
  parameter int unsigned REG_SEL = DEF_REG_SEL
);

  logic [XLEN-1:0]        wdata;
  logic [REG_SEL-1:0]     rd;
  logic                   wen;
  logic [REG_SEL-1:0]     rs1;
  logic [REG_SEL-1:0]     rs2;
  logic [XLEN-1:0]        rdata1;
  logic [XLEN-1:0]        rdata2;
  logic [NR_REG*XLEN-1:0] dbg_regs;

  modport master (
    output wdata, rd, wen, rs1, rs2,
    input  rdata1, rdata2, dbg_regs
  );

  modport slave (
    input  wdata, rd, wen, rs1, rs2,
    output rdata1, rdata2, dbg_regs
  );

endinterface

// File: rtl/gpr_regfile_keydec_key_lut_mux.sv
// Key/value lookup mux: returns the data of the first pair (MSB side) whose
// key matches, or zero when nothing matches.
module key_lut_mux #(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 8
) (
  output logic [DATA_LEN-1:0]                      out,
  input  logic [KEY_LEN-1:0]                       key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]     lut
);

  localparam int unsigned PAIR_W = KEY_LEN + DATA_LEN;

  logic              hit;
  logic [PAIR_W-1:0] pair;

  // Scan from the most significant pair so the first match wins on duplicates.
  always_comb begin
    out  = '0;
    hit  = 1'b0;
    pair = '0;
    for (int unsigned p = 0; p < NR_KEY; p++) begin
      pair = lut[(NR_KEY-1-p)*PAIR_W +: PAIR_W];
      if (!hit && (pair[PAIR_W-1 -: KEY_LEN] == key)) begin
        out = pair[DATA_LEN-1:0];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_regfile_keydec.sv
// RV64 decode-stage register file: two combinational reads, one synchronous
// write whose per-register enable comes from a key/value decode of rd.
module gpr_regfile_keydec
  import gpr_regfile_keydec_pkg::*;
#(
  parameter int unsigned     XLEN      = DEF_XLEN,
  parameter int unsigned     NR_REG    = DEF_NR_REG,
  parameter int unsigned     REG_SEL   = DEF_REG_SEL,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  gpr_regfile_keydec_if.slave  bus
);

  localparam int unsigned PAIR_W = REG_SEL + NR_REG;

  logic [NR_REG*PAIR_W-1:0]     dec_lut;
  logic [NR_REG-1:0]            onehot;
  logic [NR_REG-1:0]            wr_en;
  logic [NR_REG-1:0][XLEN-1:0]  regs;
  logic                         unused_x0_en;

  // Decode table: key k -> bit k, except key 0 which enables nothing.
  for (genvar p = 0; p < NR_REG; p++) begin : g_lut
    localparam logic [NR_REG-1:0] ONEHOT_P =
      (p == ZERO_REG) ? '0 : (NR_REG'(1) << p);
    assign dec_lut[(NR_REG-1-p)*PAIR_W +: PAIR_W] = {REG_SEL'(p), ONEHOT_P};
  end

  key_lut_mux #(
    .NR_KEY   (NR_REG),
    .KEY_LEN  (REG_SEL),
    .DATA_LEN (NR_REG)
  ) u_wen_dec (
    .out (onehot),
    .key (bus.rd),
    .lut (dec_lut)
  );

  assign wr_en        = {NR_REG{bus.wen}} & onehot;
  assign unused_x0_en = wr_en[ZERO_REG];

  // Register cells; x0 is a constant zero with no storage.
  for (genvar i = 0; i < NR_REG; i++) begin : g_cell
    if (i == ZERO_REG) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_reg
      logic [XLEN-1:0] q;

      // Async reset to RESET_VAL, load wdata when this cell is selected.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q <= RESET_VAL;
        end else if (wr_en[i]) begin
          q <= bus.wdata;
        end
      end

      assign regs[i] = q;
    end
  end

  // Combinational reads from current state; no write bypass.
  assign bus.rdata1   = regs[bus.rs1];
  assign bus.rdata2   = regs[bus.rs2];
  assign bus.dbg_regs = regs;

endmodule

// File: tb/tb_gpr_regfile_keydec.sv
// Directed bench for the GPR file and its key/value decode mux.
module tb_gpr_regfile_keydec;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [63:0] exp_regs [32];

  gpr_regfile_keydec_if bus ();

  gpr_regfile_keydec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Standalone lookup mux: pairs {1:0x11}, {2:0xAB}, {2:0xCD}; first pair in MSBs.
  logic [1:0]  lut_key;
  logic [7:0]  lut_out;
  logic [29:0] lut_tbl;

  key_lut_mux #(
    .NR_KEY   (3),
    .KEY_LEN  (2),
    .DATA_LEN (8)
  ) u_lut (
    .out (lut_out),
    .key (lut_key),
    .lut (lut_tbl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_cycle(input logic [4:0] rd, input logic [63:0] wd, input logic we);
    @(negedge clk);
    bus.rd    = rd;
    bus.wdata = wd;
    bus.wen   = we;
    @(posedge clk);
    #1;
    bus.wen   = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd31;
    #1;
    vectors++;
    if (bus.rdata1 !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_rdata1 got=%h exp=%h", bus.rdata1, 64'd0);
    end
    vectors++;
    if (bus.rdata2 !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_rdata2 got=%h exp=%h", bus.rdata2, 64'd0);
    end
    vectors++;
    if (bus.dbg_regs !== '0) begin
      miscompares++;
      $display("FAIL reset_dbg_regs not all zero");
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_write;
    @(negedge clk);
    bus.rs1   = 5'd5;
    bus.rd    = 5'd5;
    bus.wdata = 64'hDEADBEEF_CAFEF00D;
    bus.wen   = 1'b1;
    #1;
    vectors++;
    if (bus.rdata1 !== 64'd0) begin
      miscompares++;
      $display("FAIL basic_before_edge got=%h exp=%h", bus.rdata1, 64'd0);
    end
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    exp_regs[5] = 64'hDEADBEEF_CAFEF00D;
    vectors++;
    if (bus.rdata1 !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("FAIL basic_after_edge got=%h exp=%h", bus.rdata1, 64'hDEADBEEF_CAFEF00D);
    end
  endtask

  task automatic test_x0_immunity;
    write_cycle(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    bus.rs1 = 5'd0;
    #1;
    vectors++;
    if (bus.rdata1 !== 64'd0) begin
      miscompares++;
      $display("FAIL x0_read got=%h exp=%h", bus.rdata1, 64'd0);
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus.dbg_regs[i*64 +: 64] !== exp_regs[i]) begin
        miscompares++;
        $display("FAIL x0_side_effect x%0d got=%h exp=%h", i, bus.dbg_regs[i*64 +: 64], exp_regs[i]);
      end
    end
  endtask

  task automatic test_wen_gating;
    write_cycle(5'd7, 64'h55, 1'b0);
    vectors++;
    if (bus.dbg_regs[7*64 +: 64] !== 64'd0) begin
      miscompares++;
      $display("FAIL wen_off_x7 got=%h exp=%h", bus.dbg_regs[7*64 +: 64], 64'd0);
    end
    write_cycle(5'd7, 64'h55, 1'b1);
    exp_regs[7] = 64'h55;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus.dbg_regs[i*64 +: 64] !== exp_regs[i]) begin
        miscompares++;
        $display("FAIL wen_on x%0d got=%h exp=%h", i, bus.dbg_regs[i*64 +: 64], exp_regs[i]);
      end
    end
  endtask

  task automatic test_read_during_write;
    @(negedge clk);
    bus.rs1   = 5'd7;
    bus.rs2   = 5'd7;
    bus.rd    = 5'd7;
    bus.wdata = 64'h77;
    bus.wen   = 1'b1;
    #1;
    vectors++;
    if (bus.rdata1 !== 64'h55 || bus.rdata2 !== 64'h55) begin
      miscompares++;
      $display("FAIL rdw_old got=%h/%h exp=%h", bus.rdata1, bus.rdata2, 64'h55);
    end
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    exp_regs[7] = 64'h77;
    vectors++;
    if (bus.rdata1 !== 64'h77 || bus.rdata2 !== 64'h77) begin
      miscompares++;
      $display("FAIL rdw_new got=%h/%h exp=%h", bus.rdata1, bus.rdata2, 64'h77);
    end
  endtask

  task automatic test_sweep;
    for (int i = 1; i < 32; i++) begin
      write_cycle(5'(i), 64'(i * 32'h0101), 1'b1);
      exp_regs[i] = 64'(i * 32'h0101);
    end
    bus.rs1 = 5'd31;
    bus.rs2 = 5'd1;
    #1;
    vectors++;
    if (bus.rdata1 !== 64'h1F1F) begin
      miscompares++;
      $display("FAIL sweep_rdata1 got=%h exp=%h", bus.rdata1, 64'h1F1F);
    end
    vectors++;
    if (bus.rdata2 !== 64'h0101) begin
      miscompares++;
      $display("FAIL sweep_rdata2 got=%h exp=%h", bus.rdata2, 64'h0101);
    end
    vectors++;
    if (bus.dbg_regs[31*64 +: 64] !== 64'h1F1F) begin
      miscompares++;
      $display("FAIL sweep_dbg31 got=%h exp=%h", bus.dbg_regs[31*64 +: 64], 64'h1F1F);
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (bus.dbg_regs[i*64 +: 64] !== exp_regs[i]) begin
        miscompares++;
        $display("FAIL sweep x%0d got=%h exp=%h", i, bus.dbg_regs[i*64 +: 64], exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset_midrun;
    write_cycle(5'd5, 64'h1234, 1'b1);
    bus.rs1 = 5'd5;
    #1;
    vectors++;
    if (bus.rdata1 !== 64'h1234) begin
      miscompares++;
      $display("FAIL midrun_pre got=%h exp=%h", bus.rdata1, 64'h1234);
    end
    // Assert reset well away from any clock edge and check immediately.
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.rdata1 !== 64'd0) begin
      miscompares++;
      $display("FAIL midrun_async_x5 got=%h exp=%h", bus.rdata1, 64'd0);
    end
    vectors++;
    if (bus.dbg_regs !== '0) begin
      miscompares++;
      $display("FAIL midrun_async_dbg not all zero");
    end
    // Write attempted while reset is held: reset wins.
    bus.rd    = 5'd9;
    bus.wdata = 64'hABCD;
    bus.wen   = 1'b1;
    bus.rs2   = 5'd9;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.rdata2 !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_vs_write got=%h exp=%h", bus.rdata2, 64'd0);
    end
    bus.wen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) exp_regs[i] = 64'd0;
    // First edge after release accepts a write.
    write_cycle(5'd9, 64'h99, 1'b1);
    vectors++;
    if (bus.rdata2 !== 64'h99) begin
      miscompares++;
      $display("FAIL first_write_after_reset got=%h exp=%h", bus.rdata2, 64'h99);
    end
  endtask

  task automatic test_lut;
    lut_tbl = {2'd1, 8'h11, 2'd2, 8'hAB, 2'd2, 8'hCD};
    lut_key = 2'd2;
    #1;
    vectors++;
    if (lut_out !== 8'hAB) begin
      miscompares++;
      $display("FAIL lut_key2_first_match got=%h exp=%h", lut_out, 8'hAB);
    end
    lut_key = 2'd1;
    #1;
    vectors++;
    if (lut_out !== 8'h11) begin
      miscompares++;
      $display("FAIL lut_key1 got=%h exp=%h", lut_out, 8'h11);
    end
    lut_key = 2'd3;
    #1;
    vectors++;
    if (lut_out !== 8'h00) begin
      miscompares++;
      $display("FAIL lut_key3_nomatch got=%h exp=%h", lut_out, 8'h00);
    end
    lut_key = 2'd0;
    #1;
    vectors++;
    if (lut_out !== 8'h00) begin
      miscompares++;
      $display("FAIL lut_key0_nomatch got=%h exp=%h", lut_out, 8'h00);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.wen     = 1'b0;
    bus.rd      = '0;
    bus.wdata   = '0;
    bus.rs1     = '0;
    bus.rs2     = '0;
    lut_key     = '0;
    lut_tbl     = '0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 64'd0;

    test_reset;
    test_basic_write;
    test_x0_immunity;
    test_wen_gating;
    test_read_during_write;
    test_sweep;
    test_reset_midrun;
    test_lut;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
